// File: rtl/spi_sync_pkg.sv
// Shared types and constants for the oversampled SPI slave (spi_slave_sync).
package spi_sync_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LEADING  = 2'd1,
        TRAILING = 2'd2
    } edge_kind_e;

    // A toggle that leaves SCK away from its idle level is a leading edge.
    function automatic edge_kind_e classify_edge(input logic cpol, input logic level,
                                                 input logic toggled);
        edge_kind_e kind;
        if (!toggled) begin
            kind = NONE;
        end else if (level != cpol) begin
            kind = LEADING;
        end else begin
            kind = TRAILING;
        end
        return kind;
    endfunction

endpackage

// File: rtl/spi_sync_input.sv
// Synchroniser for one asynchronous pin, with an extra stage for rise/fall detection.
module spi_sync_input
    import spi_sync_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_r;
    logic                  prev_r;

    // Synchroniser chain plus the previous-value stage used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= {SYNC_DEPTH{RESET_VAL}};
            prev_r <= RESET_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], din};
            prev_r <= sync_r[SYNC_DEPTH-1];
        end
    end

    assign sync = sync_r[SYNC_DEPTH-1];
    assign rise = sync_r[SYNC_DEPTH-1] & ~prev_r;
    assign fall = ~sync_r[SYNC_DEPTH-1] & prev_r;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave with SCK/SS/MOSI oversampled in the clk domain; all four modes, run-time selected.
// Define SPI_SLAVE_SYNC_STATUS_EN to add sticky underrun/frame_err flags and status_clr.
module spi_slave_sync
    import spi_sync_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] TX_IDLE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    ,
    output logic             underrun,
    output logic             frame_err,
    input  logic             status_clr
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic                  sck_sync_s, sck_rise_s, sck_fall_s;
    logic                  ss_sync_s, ss_rise_s, ss_fall_s;
    logic [SYNC_DEPTH-1:0] mosi_sync_r;
    logic                  mosi_bit_s;

    mode_t                 mode_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [WIDTH-1:0]      rx_shift_r, tx_shift_r, rx_data_r;
    logic                  rx_valid_r, busy_r;

    edge_kind_e            edge_kind_s;
    logic                  sample_s, shift_s, load_s;
    logic [WIDTH-1:0]      rx_next_s;

    spi_sync_input #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .sync (sck_sync_s),
        .rise (sck_rise_s),
        .fall (sck_fall_s)
    );

    spi_sync_input #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss),
        .sync (ss_sync_s),
        .rise (ss_rise_s),
        .fall (ss_fall_s)
    );

    // MOSI only needs to be brought into the clk domain; its edges are irrelevant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mosi_sync_r <= '0;
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_DEPTH-2:0], mosi};
        end
    end

    assign mosi_bit_s = mosi_sync_r[SYNC_DEPTH-1];

    // Classify SCK edges and decide whether this cycle samples, shifts or loads.
    always_comb begin
        edge_kind_s = NONE;
        sample_s    = 1'b0;
        shift_s     = 1'b0;
        load_s      = 1'b0;
        rx_next_s   = {rx_shift_r[WIDTH-2:0], mosi_bit_s};
        if (busy_r && !ss_rise_s) begin
            edge_kind_s = classify_edge(mode_r.cpol, sck_sync_s, sck_rise_s | sck_fall_s);
        end else begin
            edge_kind_s = NONE;
        end
        if (ss_fall_s) begin
            load_s = 1'b1;
        end else begin
            case (edge_kind_s)
                LEADING: begin
                    sample_s = !mode_r.cpha;
                    // CPHA=1 keeps the preloaded MSB through the word's first leading edge
                    shift_s  = mode_r.cpha && (cnt_r != '0);
                end
                TRAILING: begin
                    sample_s = mode_r.cpha;
                    load_s   = mode_r.cpha ? (cnt_r == LAST_BIT) : (cnt_r == '0);
                    shift_s  = !mode_r.cpha && (cnt_r != '0);
                end
                default: begin
                    sample_s = 1'b0;
                    shift_s  = 1'b0;
                    load_s   = 1'b0;
                end
            endcase
        end
    end

    // Frame state: mode latch, bit counter, shift registers and the receive strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_r     <= '0;
            cnt_r      <= '0;
            rx_shift_r <= '0;
            tx_shift_r <= '0;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            busy_r     <= ~ss_sync_s;
            rx_valid_r <= 1'b0;
            if (ss_fall_s) begin
                mode_r     <= mode_t'(mode);
                cnt_r      <= '0;
                rx_shift_r <= '0;
            end else if (ss_rise_s) begin
                cnt_r      <= '0;
                rx_shift_r <= '0;
            end else if (sample_s) begin
                rx_shift_r <= rx_next_s;
                if (cnt_r == LAST_BIT) begin
                    cnt_r      <= '0;
                    rx_data_r  <= rx_next_s;
                    rx_valid_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
            if (load_s) begin
                tx_shift_r <= tx_valid ? tx_data : TX_IDLE;
            end else if (shift_s) begin
                tx_shift_r <= {tx_shift_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign miso     = tx_shift_r[WIDTH-1];
    assign miso_oe  = busy_r;
    assign busy     = busy_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    // Ready is offered in the cycle whose closing edge captures tx_data.
    assign tx_ready = rst & tx_valid & load_s;

`ifdef SPI_SLAVE_SYNC_STATUS_EN
    logic underrun_r, frame_err_r;

    // Sticky status flags; a new event outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            underrun_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (load_s && !tx_valid) begin
                underrun_r <= 1'b1;
            end else if (status_clr) begin
                underrun_r <= 1'b0;
            end
            if (ss_rise_s && (cnt_r != '0)) begin
                frame_err_r <= 1'b1;
            end else if (status_clr) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    assign underrun  = underrun_r;
    assign frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync (WIDTH=16): acts as SPI master, scoreboards RX words and MISO words.
module tb_spi_slave_sync;

    localparam int         W    = 16;
    localparam logic [W-1:0] IDLE = '1;
    localparam int         HALF = 6;

    logic         clk = 1'b0;
    logic         rst, sck, ss, mosi, miso, miso_oe, tx_valid, tx_ready, rx_valid, busy;
    logic [1:0]   mode;
    logic [W-1:0] tx_data, rx_data;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    logic         underrun, frame_err, status_clr;
    bit           und_m = 1'b0, fe_m = 1'b0;
`endif

    int           checks = 0, errors = 0, n_ready = 0;
    logic [W-1:0] exp_rx_q[$], exp_miso_q[$], obs_miso_q[$], tx_q[$], send_q[$], offer_q[$];
    logic [W-1:0] last_rx = '0;

    always #5 clk = ~clk;

    spi_slave_sync #(.WIDTH(W), .TX_IDLE(IDLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .mode       (mode),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy)
`ifdef SPI_SLAVE_SYNC_STATUS_EN
        ,
        .underrun   (underrun),
        .frame_err  (frame_err),
        .status_clr (status_clr)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    // Advance n clocks; acts as the TX source, presenting the next queued word after a handshake.
    task automatic step(input int n);
        logic take;
        repeat (n) begin
            @(negedge clk);
            take = tx_ready;
            @(posedge clk);
            #1;
            if (take && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                tx_valid = (tx_q.size() > 0);
                if (tx_q.size() > 0) tx_data = tx_q[0];
            end
        end
    endtask

    // One SS frame of nbits bits using send_q as MOSI words and offer_q as TX words.
    task automatic run_frame(input logic [1:0] m, input int nbits, input bit rst_mid);
        int           nfull, loads, ready0, n_offer, wi, bi;
        logic [W-1:0] cap;
        nfull   = nbits / W;
        n_offer = offer_q.size();
        loads   = rst_mid ? 1 : nfull + 1;
        for (int k = 0; k < nfull; k++) begin
            exp_rx_q.push_back(send_q[k]);
            exp_miso_q.push_back((k < n_offer) ? offer_q[k] : IDLE);
        end
        tx_q     = offer_q;
        tx_valid = (n_offer > 0);
        if (n_offer > 0) tx_data = tx_q[0];
        ready0 = n_ready;
        mode   = m;
        sck    = m[1];
        step(HALF);
        mosi = send_q[0][W-1];
        ss   = 1'b0;
        step(HALF);
        chk("busy_in_frame", 32'(busy), 32'd1);
        chk("miso_oe_in_frame", 32'(miso_oe), 32'd1);
        mode = 2'($urandom);
        cap  = '0;
        for (int b = 0; b < nbits; b++) begin
            wi = b / W;
            bi = W - 1 - (b % W);
            if (!m[0]) begin
                sck = ~m[1];
                cap = {cap[W-2:0], miso};
                if (bi == 0) obs_miso_q.push_back(cap);
                step(HALF);
                sck = m[1];
                if (b + 1 < nbits) mosi = send_q[(b + 1) / W][W - 1 - ((b + 1) % W)];
                step(HALF);
            end else begin
                sck  = ~m[1];
                mosi = send_q[wi][bi];
                step(HALF);
                sck = m[1];
                cap = {cap[W-2:0], miso};
                if (bi == 0) obs_miso_q.push_back(cap);
                step(HALF);
            end
        end
        if (rst_mid) begin
            ss  = 1'b1;
            rst = 1'b0;
            step(1);
            chk("rstmid_miso", 32'(miso), 32'd0);
            chk("rstmid_miso_oe", 32'(miso_oe), 32'd0);
            chk("rstmid_busy", 32'(busy), 32'd0);
            chk("rstmid_tx_ready", 32'(tx_ready), 32'd0);
            chk("rstmid_rx_valid", 32'(rx_valid), 32'd0);
            chk("rstmid_rx_data", 32'(rx_data), 32'd0);
            rst = 1'b1;
            step(2);
        end else begin
            step(HALF);
            ss = 1'b1;
            step(HALF + 2);
            chk("busy_after_frame", 32'(busy), 32'd0);
            if (nbits % W != 0) chk("rx_data_held", 32'(rx_data), 32'(last_rx));
        end
        chk("tx_ready_count", 32'(n_ready - ready0), 32'((loads < n_offer) ? loads : n_offer));
`ifdef SPI_SLAVE_SYNC_STATUS_EN
        if (rst_mid) begin
            und_m = 1'b0;
            fe_m  = 1'b0;
        end else begin
            if (n_offer < loads) und_m = 1'b1;
            if (nbits % W != 0) fe_m = 1'b1;
        end
        chk("underrun", 32'(underrun), 32'(und_m));
        chk("frame_err", 32'(frame_err), 32'(fe_m));
`endif
        tx_q.delete();
        tx_valid = 1'b0;
    endtask

    // Scoreboard monitor: counts handshakes and compares every delivered word.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_ready) begin
                n_ready++;
                chk("tx_ready_without_valid", 32'(tx_valid), 32'd1);
            end
            if (rx_valid) begin
                if (exp_rx_q.size() > 0) begin
                    chk("rx_word", 32'(rx_data), 32'(exp_rx_q.pop_front()));
                    last_rx = rx_data;
                end else begin
                    chk("rx_valid_spurious", 32'(rx_valid), 32'd0);
                end
            end
            while (obs_miso_q.size() > 0 && exp_miso_q.size() > 0) begin
                chk("miso_word", 32'(obs_miso_q.pop_front()), 32'(exp_miso_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, no;
        rst = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; mode = 2'd0;
        tx_valid = 1'b0; tx_data = '0;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
        status_clr = 1'b0;
`endif
        step(4);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_miso_oe", 32'(miso_oe), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tx_ready", 32'(tx_ready), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b1;
        step(4);

        send_q = {16'h3CC3}; offer_q = {16'hA55A};
        run_frame(2'd0, W, 1'b0);
        for (int m = 0; m < 4; m++) begin
            send_q = {16'h1234}; offer_q = {16'hBEEF};
            run_frame(2'(m), W, 1'b0);
        end
        send_q = {W'($urandom), W'($urandom)}; offer_q = {W'($urandom), W'($urandom)};
        run_frame(2'($urandom), 2 * W, 1'b0);
        send_q = {W'($urandom)}; offer_q = {};
        run_frame(2'd0, W, 1'b0);
`ifdef SPI_SLAVE_SYNC_STATUS_EN
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        und_m = 1'b0;
        fe_m  = 1'b0;
        chk("underrun_cleared", 32'(underrun), 32'd0);
`endif
        send_q = {W'($urandom)}; offer_q = {W'($urandom)};
        run_frame(2'd3, 5, 1'b0);
        send_q = {W'($urandom)}; offer_q = {W'($urandom)};
        run_frame(2'd0, 7, 1'b1);
        send_q = {W'($urandom)}; offer_q = {W'($urandom)};
        run_frame(2'd0, W, 1'b0);

        for (int f = 0; f < 10; f++) begin
            nw = int'($urandom_range(1, 3));
            no = int'($urandom_range(0, nw + 1));
            send_q = {};
            offer_q = {};
            for (int k = 0; k < nw; k++) send_q.push_back(W'($urandom));
            for (int k = 0; k < no; k++) offer_q.push_back(W'($urandom));
            run_frame(2'($urandom), nw * W, 1'b0);
        end

        step(20);
        chk("rx_words_outstanding", 32'(exp_rx_q.size()), 32'd0);
        chk("miso_words_outstanding", 32'(exp_miso_q.size()), 32'd0);
        chk("miso_words_unmatched", 32'(obs_miso_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised, fully synchronous SPI slave: SCK, SS and MOSI are oversampled in the system clock domain, so no logic is clocked by SCK. It supports configurable word width, all four SPI modes selected at run time, and a valid/ready transmit handshake with a one-cycle receive strobe. It sits between an external SPI master and the register/command logic, replacing the fixed 8-bit, SCK-clocked slave.

## Interface
- WIDTH, 8: word length in bits, 2..32.
- TX_IDLE, all ones: word shifted out when no TX word is offered at a load point.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- sck  in  1  SPI clock, asynchronous to clk.
- ss  in  1  slave select, active-low, asynchronous.
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- miso_oe  out  1  output enable, high while synchronised SS is active.
- mode  in  2  {CPOL, CPHA}; latched at SS assertion.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  one-cycle pulse; tx_data is consumed this cycle.
- rx_data  out  WIDTH  last complete received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse; rx_data was updated this cycle.
- busy  out  1  high while synchronised SS is active.

## Operation
- Synchronisation: sck, ss and mosi each pass through 2 flip-flops. Edges of sck and ss are detected from the 2nd and 3rd stages.
- Leading edge = SCK leaving its CPOL idle level; trailing edge = SCK returning to it.
- Sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. The other edge is the shift edge.
- On SS fall:
  - latch mode;
  - clear the bit counter;
  - perform a load.
- Load:
  - if tx_valid=1, the TX shift register takes tx_data and tx_ready pulses that cycle;
  - otherwise it takes TX_IDLE and the underrun flag is set.
- miso is always the MSB of the TX shift register. Data is MSB first in both directions.
- On a sample edge:
  - the RX shift register shifts in the synchronised mosi;
  - the counter increments;
  - at count WIDTH-1 the counter wraps to 0, rx_data is written with the full word and rx_valid pulses.
- On a shift edge, the TX register shifts left, with two exceptions:
  - CPHA=1: the first leading edge of each word does not shift;
  - load point: the trailing edge that completes bit WIDTH-1 performs a load instead of a shift, which gives back-to-back words with no SS gap.
- On SS rise:
  - abort the word;
  - clear the counter and the RX shift register;
  - rx_data is not updated;
  - if the counter was nonzero, set the frame error flag;
  - mode changes take effect only at the next SS fall.
- Reset clears every register:
  - miso=0, miso_oe=0, busy=0, tx_ready=0, rx_valid=0, rx_data=0, mode latch=0, counter=0;
  - ss synchroniser stages reset to 1 and sck stages to 0;
  - rst low during a transfer aborts it with no rx_valid and no tx_ready.
- SCK edges while SS is inactive are ignored.

## Timing
- Pin-to-detected-edge latency: 3 clk.
- rx_valid asserts 3 clk after the pin edge that carries the last sample.
- Master SCK half-period ≥ 4 clk. MOSI must be stable from ≥ 3 clk before the sample edge.
- miso changes 3 clk after the shift edge at the pin.
- SS fall must precede the first SCK edge by ≥ 4 clk.
- tx_ready and rx_valid in the same cycle are legal and independent.

## Configuration
- SPI_SLAVE_SYNC_STATUS_EN defined:
  - adds outputs underrun and frame_err, sticky, reset 0;
  - adds input status_clr, which clears both; a set event in the same cycle as status_clr wins.
- Undefined: these ports and flags are absent and underrun loads TX_IDLE silently.

## Structure
- Package spi_sync_pkg holds:
  - the mode typedef (struct of cpol, cpha);
  - the edge-kind enum (NONE, LEADING, TRAILING);
  - the synchroniser depth constant, 2.
- Sub-module spi_sync_input: 2-FF synchroniser plus rise/fall detect, instantiated for sck and ss (mosi uses the sync path only).

## Test plan
- Mode 0, WIDTH=8, tx_data=0xA5 valid, master sends 0x3C -> miso bits 1010_0101, rx_data=0x3C with a single rx_valid pulse, one tx_ready at SS fall.
- All modes 0–3, WIDTH=16, master sends 0x1234 while slave sends 0xBEEF -> both sides match in every mode.
- Two back-to-back words without SS release, second tx_valid held high -> second tx_ready at the last trailing edge of word 1, two rx_valid pulses.
- tx_valid=0 at SS fall -> miso shifts 0xFF; with the macro, underrun=1 until status_clr.
- SS released after 5 bits -> no rx_valid, rx_data unchanged; with the macro, frame_err=1.
- rst low for 1 clk mid-word -> all outputs 0 next cycle; after SS re-assert, a fresh transfer completes correctly.
